pwm_ramp_ctrl: RTL

//  Sequencer/configurator for one pwm channel (generator pulse or drive output).
//  - Holds host-written shadow settings and applies them only at period boundaries (pwm load).
//  - Ramps the active duty edge t1 toward a target by a fixed step per period: soft start/stop.
//  - Owns the pwm synchronous clear: the channel is held cleared while idle.

---
 rtl/pwm_ramp_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for one pwm channel: shadow settings applied at period boundaries,
// soft start/stop by ramping the t1 edge, and ownership of the pwm sync clear.
module pwm_ramp_ctrl #(
  parameter int          WIDTH    = 32,
  parameter int unsigned PER_INIT = 999
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             sclr,
  input  logic             wr_per,
  input  logic             wr_phase,
  input  logic             wr_tgt,
  input  logic             wr_step,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             stop,
  input  logic             pwm_load,
  output logic [WIDTH-1:0] pwm_per,
  output logic [WIDTH-1:0] pwm_t0,
  output logic [WIDTH-1:0] pwm_t1,
  output logic             pwm_sclr,
  output logic             busy,
  output logic             at_target
);

  localparam logic [WIDTH-1:0] PER_RST = WIDTH'(PER_INIT);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DOWN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_per, sh_phase, sh_tgt, step;
  logic [WIDTH-1:0] eff, up_t1, dn_raw, dn_t1;
  logic [WIDTH:0]   sum;

  // eff uses the period being applied at this load, so a shrinking period clamps t1 at once
  always_comb begin
    eff    = (sh_tgt < sh_per) ? sh_tgt : sh_per;
    sum    = {1'b0, pwm_t1} + {1'b0, step};
    up_t1  = (step == '0 || sum > {1'b0, eff}) ? eff : sum[WIDTH-1:0];
    dn_raw = (step == '0 || pwm_t1 <= step) ? '0 : pwm_t1 - step;
    dn_t1  = (dn_raw > eff) ? eff : dn_raw;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr || sclr) begin
      state     <= IDLE;
      sh_per    <= PER_RST;
      sh_phase  <= '0;
      sh_tgt    <= '0;
      step      <= '0;
      pwm_per   <= PER_RST;
      pwm_t0    <= '0;
      pwm_t1    <= '0;
      pwm_sclr  <= 1'b1;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      if (wr_per)   sh_per   <= din;
      if (wr_phase) sh_phase <= din;
      if (wr_tgt)   sh_tgt   <= din;
      if (wr_step)  step     <= din;

      case (state)
        IDLE: if (start && !stop) begin
          state     <= ARM;
          pwm_sclr  <= 1'b0;
          busy      <= 1'b1;
          pwm_per   <= sh_per;
          pwm_t0    <= sh_phase;
          pwm_t1    <= '0;
          at_target <= 1'b0;
        end
        // one cycle for the pwm counter to restart; loads here are dropped
        ARM: if (stop) begin
          state    <= IDLE;
          pwm_sclr <= 1'b1;
          busy     <= 1'b0;
        end else begin
          state <= RUN;
        end
        RUN: if (stop) begin
          state     <= DOWN;
          at_target <= 1'b0;
          if (pwm_load) begin
            pwm_per <= sh_per;
            pwm_t0  <= sh_phase;
            pwm_t1  <= dn_t1;
          end
        end else if (pwm_load) begin
          pwm_per   <= sh_per;
          pwm_t0    <= sh_phase;
          pwm_t1    <= up_t1;
          at_target <= (up_t1 == eff);
        end
        DOWN: if (pwm_load) begin
          pwm_per <= sh_per;
          pwm_t0  <= sh_phase;
          if (pwm_t1 == '0) begin
            state    <= IDLE;
            pwm_sclr <= 1'b1;
            busy     <= 1'b0;
          end else begin
            pwm_t1 <= dn_t1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
